// File: rtl/tiled_window_multiplier.sv
// Iterative tiled unsigned multiplier with valid/ready handshakes and a selectable product window.
// Define TILED_MUL_ROUND_EN to round the window half-up on product bit RES_LO-1.
module tiled_window_multiplier #(
  parameter int unsigned MUL_SIZE = 80,
  parameter int unsigned TILE     = 20,
  parameter int unsigned LANES    = 4,
  parameter int unsigned RES_LO   = 80,
  parameter int unsigned RES_W    = 78
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_SIZE-1:0] a,
  input  logic [MUL_SIZE-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    res,
  output logic                busy
);

  localparam int unsigned N    = MUL_SIZE / TILE;
  localparam int unsigned P    = N * N;
  localparam int unsigned G    = (P + LANES - 1) / LANES;
  localparam int unsigned AccW = 2 * MUL_SIZE;
  localparam int unsigned PrdW = 2 * TILE;
  localparam int unsigned GW   = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned ShW  = $clog2(AccW);

  typedef enum logic [1:0] {StIdle, StMul, StFlush, StOut} state_e;

  state_e              state_q;
  logic [GW-1:0]       g_q;
  logic [MUL_SIZE-1:0] a_q, b_q;
  logic [AccW-1:0]     acc_q, acc_sum;
  logic [PrdW-1:0]     prod_q [LANES];
  logic [PrdW-1:0]     prod_d [LANES];
  logic [ShW-1:0]      shamt_q [LANES];
  logic [ShW-1:0]      shamt_d [LANES];
  logic [RES_W-1:0]    res_q, res_next;
  logic                out_valid_q;

  // Tile products of group g_q; lanes past the last tile product contribute zero.
  always_comb begin
    int unsigned k, ti, tj;
    logic [TILE-1:0] ta, tb;
    k  = 0;
    ti = 0;
    tj = 0;
    ta = '0;
    tb = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_d[l]  = '0;
      shamt_d[l] = '0;
      k = LANES * 32'(g_q) + l;
      if (k < P) begin
        ti = k / N;
        tj = k % N;
        ta = a_q[ti*TILE +: TILE];
        tb = b_q[tj*TILE +: TILE];
        prod_d[l]  = PrdW'(ta) * PrdW'(tb);
        shamt_d[l] = ShW'((ti + tj) * TILE);
      end
    end
  end

  always_comb begin
    acc_sum = acc_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      acc_sum = acc_sum + (AccW'(prod_q[l]) << shamt_q[l]);
    end
  end

  always_comb begin
    res_next = acc_q[RES_LO +: RES_W];
`ifdef TILED_MUL_ROUND_EN
    // Half-up rounding wraps modulo 2^RES_W rather than saturating.
    if (RES_LO > 0) begin
      res_next = res_next + RES_W'(acc_q[(RES_LO > 0) ? RES_LO - 1 : 0]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        prod_q[l]  <= '0;
        shamt_q[l] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            g_q     <= '0;
            state_q <= StMul;
            for (int unsigned l = 0; l < LANES; l++) begin
              prod_q[l]  <= '0;
              shamt_q[l] <= '0;
            end
          end
        end
        StMul: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            prod_q[l]  <= prod_d[l];
            shamt_q[l] <= shamt_d[l];
          end
          acc_q <= acc_sum;
          g_q   <= g_q + 1'b1;
          if (g_q == GW'(G - 1)) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          acc_q   <= acc_sum;
          state_q <= StOut;
        end
        StOut: begin
          // First OUT cycle loads the result register; then hold until accepted.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            res_q       <= res_next;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule
